// File: rtl/fifo_read_if.sv
// Handshake and data bundle between fifo_read, the byte FIFO and the frame requester.
// master = fifo_read side, slave = FIFO/requester side.
interface fifo_read_if;
  logic        fifo_empty;
  logic [7:0]  fifo_rxd;
  logic        fifo_rxen;
  logic        fs;
  logic        fd;
  logic [11:0] data_len;
  logic [7:0]  part;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    input  fifo_empty, fifo_rxd, fs, data_len,
    output fifo_rxen, fd, part, err, err_cnt
  );

  modport slave (
    output fifo_empty, fifo_rxd, fs, data_len,
    input  fifo_rxen, fd, part, err, err_cnt
  );
endinterface

// File: rtl/fifo_read.sv
// Drains one test-pattern frame (55 AA part 03 04 ..) per fs request and checks every byte.
// Define FIFO_READ_TIMEOUT_EN to add an idle-read watchdog that aborts a stalled frame.
module fifo_read #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic         clk_i,
  input logic         rst_ni,
  fifo_read_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StWork = 2'd2;
  localparam logic [1:0] StLast = 2'd3;

  localparam logic [11:0] MinLen = 12'd4;
  localparam logic [11:0] MaxLen = 12'd128;

  if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_timeout_range
    $error("fifo_read: TIMEOUT must be in 2..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] req_q, req_d;
  logic [11:0] chk_q, chk_d;
  logic        rd_vld_q;
  logic [7:0]  part_q, part_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        rxen;
  logic [7:0]  exp_byte;

`ifdef FIFO_READ_TIMEOUT_EN
  localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);
  logic [15:0] wdog_q, wdog_d;
`endif

  // Issue a read only while bytes remain to be requested, so the FIFO is never over-read.
  assign rxen = (state_q == StWork) && !bus.fifo_empty && (req_q < len_q);

  always_comb begin
    exp_byte = chk_q[7:0];
    if (chk_q == 12'd0) begin
      exp_byte = 8'h55;
    end else if (chk_q == 12'd1) begin
      exp_byte = 8'hAA;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_d     = req_q;
    chk_d     = chk_q;
    part_d    = part_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
`ifdef FIFO_READ_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.fs) begin
          state_d = StPrep;
        end
      end

      StPrep: begin
        len_d     = bus.data_len;
        req_d     = '0;
        chk_d     = '0;
        err_d     = 1'b0;
        err_cnt_d = '0;
`ifdef FIFO_READ_TIMEOUT_EN
        wdog_d    = '0;
`endif
        if ((bus.data_len < MinLen) || (bus.data_len > MaxLen)) begin
          err_d   = 1'b1;
          state_d = StLast;
        end else begin
          state_d = StWork;
        end
      end

      StWork: begin
        if (rxen) begin
          req_d = req_q + 12'd1;
        end
        if (rd_vld_q) begin
          chk_d = chk_q + 12'd1;
          if (chk_q == 12'd2) begin
            part_d = bus.fifo_rxd;
          end else if (bus.fifo_rxd != exp_byte) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
          if (chk_q == (len_q - 12'd1)) begin
            state_d = StLast;
          end
        end
`ifdef FIFO_READ_TIMEOUT_EN
        // Watchdog only counts cycles without returned data; a timeout leaves err_cnt alone.
        if (rd_vld_q) begin
          wdog_d = '0;
        end else if (wdog_q == WdogLast) begin
          err_d   = 1'b1;
          state_d = StLast;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end

      StLast: begin
        if (!bus.fs) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      req_q     <= '0;
      chk_q     <= '0;
      rd_vld_q  <= 1'b0;
      part_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      req_q     <= req_d;
      chk_q     <= chk_d;
      rd_vld_q  <= rxen;
      part_q    <= part_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef FIFO_READ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign bus.fifo_rxen = rxen;
  assign bus.fd        = (state_q == StLast);
  assign bus.part      = part_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fifo_read.sv
// Bench for fifo_read: directed frames from the test plan plus random frames, checked
// against a frame-level reference model of the pattern check.
module tb_fifo_read;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_read_if bus ();

  fifo_read #(
    .TIMEOUT(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Byte FIFO model: initial block owns wr_ptr, the clocked process owns rd_ptr.
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       hold_empty = 1'b0;
  int         viol = 0;

  assign bus.fifo_empty = hold_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rxen) begin
      bus.fifo_rxd <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_rxen && bus.fifo_empty) viol++;
  end

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] frame [0:255];
  logic [7:0] part_m = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pattern(input int i);
    if (i == 0) return 8'h55;
    if (i == 1) return 8'hAA;
    return 8'(i);
  endfunction

  task automatic build(input int len, input int ncorrupt);
    for (int i = 0; i < 256; i++) frame[i] = pattern(i);
    frame[2] = 8'($urandom_range(0, 255));
    for (int k = 0; k < ncorrupt; k++) frame[$urandom_range(0, len - 1)] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mem[wr_ptr] = frame[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Whole-frame outcome from the pattern rules: length legality, then byte-by-byte compare.
  task automatic model(input int len, output logic e, output logic [7:0] ec);
    int bad = 0;
    e = 1'b0;
    if (len < 4 || len > 128) begin
      e = 1'b1;
    end else begin
      part_m = frame[2];
      for (int i = 0; i < len; i++) if (i != 2 && frame[i] != pattern(i)) bad++;
      e = (bad > 0);
    end
    ec = (bad > 255) ? 8'd255 : 8'(bad);
  endtask

  task automatic run_frame(input string tag, input int len, input int npush, input int stall);
    logic       e;
    logic [7:0] ec;
    int         start;
    int         cyc = 0;
    bit         valid = (len >= 4 && len <= 128);
    push_range(0, npush);
    model(len, e, ec);
    start = rd_ptr;
    bus.data_len = 12'(len);
    @(negedge clk);
    bus.fs = 1'b1;
    while (!bus.fd && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stall == 1) hold_empty = !hold_empty;
      else if (stall == 2) hold_empty = ($urandom_range(0, 3) == 0);
    end
    hold_empty = 1'b0;
    check({tag, "_fd"}, 32'(bus.fd), 32'd1);
    // fs sampled, PREP, one cycle per byte, one data-latency cycle
    if (stall == 0) check({tag, "_lat"}, cyc, valid ? len + 3 : 2);
    check({tag, "_reads"}, rd_ptr - start, valid ? len : 0);
    check({tag, "_err"}, 32'(bus.err), 32'(e));
    check({tag, "_cnt"}, 32'(bus.err_cnt), 32'(ec));
    check({tag, "_part"}, 32'(bus.part), 32'(part_m));
    bus.fs = 1'b0;
    @(negedge clk);
    check({tag, "_fd_drop"}, 32'(bus.fd), 32'd0);
    wr_ptr = rd_ptr;
  endtask

  initial begin
    bus.fs = 1'b0;
    bus.data_len = '0;
    repeat (3) @(negedge clk);
    check("rst_fd", 32'(bus.fd), 32'd0);
    check("rst_rxen", 32'(bus.fifo_rxen), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_part", 32'(bus.part), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    build(16, 0);
    frame[2] = 8'h3C;
    run_frame("basic16", 16, 16, 0);

    build(128, 0);
    frame[10] = 8'hFF;
    frame[20] = 8'hFF;
    run_frame("corrupt128", 128, 129, 0);

    build(8, 0);
    run_frame("toggle8", 8, 8, 1);
    check("toggle8_viol", viol, 0);

    build(8, 0);
    run_frame("len3", 3, 4, 0);
    run_frame("len200", 200, 4, 0);

    // Reset in the middle of a frame
    build(16, 0);
    push_range(0, 16);
    bus.data_len = 12'd16;
    @(negedge clk);
    bus.fs = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_fd", 32'(bus.fd), 32'd0);
    check("midrst_rxen", 32'(bus.fifo_rxen), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    check("midrst_cnt", 32'(bus.err_cnt), 32'd0);
    check("midrst_part", 32'(bus.part), 32'd0);
    @(negedge clk);
    bus.fs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    part_m = 8'h00;
    wr_ptr = rd_ptr;
    @(negedge clk);
    build(16, 0);
    run_frame("after_rst", 16, 16, 0);

    // Stalled frame: only half the bytes ever arrive
    begin
      int start;
      build(10, 0);
      push_range(0, 5);
      start = rd_ptr;
      bus.data_len = 12'd10;
      @(negedge clk);
      bus.fs = 1'b1;
      for (int c = 0; c < 60 && !bus.fd; c++) @(negedge clk);
`ifdef FIFO_READ_TIMEOUT_EN
      part_m = frame[2];
      check("wdog_fd", 32'(bus.fd), 32'd1);
      check("wdog_err", 32'(bus.err), 32'd1);
      check("wdog_cnt", 32'(bus.err_cnt), 32'd0);
      check("wdog_reads", rd_ptr - start, 5);
      check("wdog_part", 32'(bus.part), 32'(part_m));
`else
      check("stall_fd", 32'(bus.fd), 32'd0);
      check("stall_reads", rd_ptr - start, 5);
      push_range(5, 10);
      for (int c = 0; c < 60 && !bus.fd; c++) @(negedge clk);
      check("resume_fd", 32'(bus.fd), 32'd1);
      check("resume_err", 32'(bus.err), 32'd0);
      check("resume_reads", rd_ptr - start, 10);
      part_m = frame[2];
`endif
      bus.fs = 1'b0;
      @(negedge clk);
      check("stall_fd_drop", 32'(bus.fd), 32'd0);
      wr_ptr = rd_ptr;
    end

    for (int n = 0; n < 20; n++) begin
      int len = $urandom_range(0, 140);
      int npush;
      npush = (len >= 4 && len <= 128) ? len + $urandom_range(0, 2) : 4;
      build((len < 4) ? 4 : len, $urandom_range(0, 3));
      run_frame($sformatf("rand%0d", n), len, npush, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    check("no_read_while_empty", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
